// File: rtl/x_bus_arbiter_if.sv
`default_nettype none
// ====================================================================
// x_bus_arbiter_if : requester-side and X-bus signals of the arbiter
// rev 1.0
// ====================================================================
interface x_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) ();
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         rdata;
  logic [AW-1:0]         xa_addr;
  logic [DW-1:0]         xa_data_wr;
  logic                  xa_wr_s;
  logic                  xa_rd_s;
  logic [DW-1:0]         xa_data_rd;

  modport master (
    input  req, req_we, req_addr, req_wdata, xa_data_rd,
    output gnt, done, rdata, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, xa_data_rd,
    input  gnt, done, rdata, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
  );
endinterface
`default_nettype wire

// File: rtl/x_bus_arbiter.sv
`default_nettype none
// ====================================================================
// x_bus_arbiter : round-robin sequencer sharing one X-bus
// rev 1.0
// ====================================================================
module x_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int WR_CYCLES  = 1,
  parameter int RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  x_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]    c_WR_LAST = 4'(WR_CYCLES);
  localparam logic [3:0]    c_RD_LAST = 4'(RD_LATENCY);
  localparam logic [IW-1:0] c_RR_INIT = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WR_CYCLES < 1 || WR_CYCLES > 15 ||
      RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_param_check
    $error("x_bus_arbiter: parameter out of legal range");
  end

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [IW-1:0]      r_rr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [DW-1:0]      r_rdata;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic               r_wr_s;
  logic               r_rd_s;

  logic               w_any;
  logic [IW-1:0]      w_cand;
  logic [IW-1:0]      w_pick;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_wdata;

  // Search upward from rr+1 with wrap; the first set bit wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(r_rr) + k) % NUM_REQ);
      if (!w_any && bus.req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick == IW'(k)) begin
        w_onehot[k] = 1'b1;
        w_we        = bus.req_we[k];
        w_addr      = bus.req_addr[k*AW +: AW];
        w_wdata     = bus.req_wdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rr    <= c_RR_INIT;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr_s  <= 1'b0;
      r_rd_s  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_rr    <= w_pick;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cnt   <= 4'd1;
            if (w_we) begin
              r_wr_s  <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_rd_s  <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (r_cnt == c_WR_LAST) begin
            r_wr_s  <= 1'b0;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_READ: begin
          if (r_cnt == c_RD_LAST) begin
            r_rdata <= bus.xa_data_rd;
            r_rd_s  <= 1'b0;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.rdata      = r_rdata;
  assign bus.xa_addr    = r_addr;
  assign bus.xa_data_wr = r_wdata;
  assign bus.xa_wr_s    = r_wr_s;
  assign bus.xa_rd_s    = r_rd_s;
endmodule
`default_nettype wire

// File: tb/tb_x_bus_arbiter.sv
`default_nettype none
// ====================================================================
// tb_x_bus_arbiter : directed scoreboard bench for x_bus_arbiter
// rev 1.0
// ====================================================================
module tb_x_bus_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int WR_CYCLES  = 1;
  localparam int RD_LATENCY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  x_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  x_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW),
    .WR_CYCLES(WR_CYCLES), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            idx;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rd_hi       = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] slave_val(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA55A);
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({bus.gnt, bus.done, bus.rdata, bus.xa_addr, bus.xa_data_wr,
                bus.xa_wr_s, bus.xa_rd_s});
  endfunction

  // Slave: read data is valid only in the cycle ending RD_LATENCY cycles after the strobe rose.
  always @(negedge clk) begin
    if (bus.xa_rd_s) rd_hi = rd_hi + 1;
    else             rd_hi = 0;
    bus.xa_data_rd = (rd_hi == RD_LATENCY) ? slave_val(bus.xa_addr) : 16'hDEAD;
  end

  // Bus and completion monitor against the scoreboard.
  always @(negedge clk) begin
    txn_t t;
    if (bus.xa_wr_s || bus.xa_rd_s) begin
      check("strobe_excl", 64'(bus.xa_wr_s & bus.xa_rd_s), 64'd0);
      check("strobe_has_txn", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        t = sb[0];
        check("strobe_kind", 64'(bus.xa_wr_s), 64'(t.we));
        check("gnt_owner", 64'(bus.gnt), 64'd1 << t.idx);
        check("bus_addr", 64'(bus.xa_addr), 64'(t.addr));
        if (t.we) check("bus_wdata", 64'(bus.xa_data_wr), 64'(t.wdata));
      end
    end
    if (bus.done != '0) begin
      check("done_has_txn", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        t = sb.pop_front();
        check("done_onehot", 64'(bus.done), 64'd1 << t.idx);
        if (!t.we) check("rdata", 64'(bus.rdata), 64'(slave_val(t.addr)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req[i]                = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic expect_txn(input int i, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    sb.push_back('{idx: i, we: we, addr: a, wdata: d});
  endtask

  // Run until n dones (bounded); checks spacing between consecutive grant starts.
  task automatic run(input int n, input bit drop_each, input string tag);
    int                 seen       = 0;
    int                 last_start = -1;
    bit                 last_we    = 1'b0;
    logic [NUM_REQ-1:0] prev_gnt   = '0;
    for (int c = 0; c < 25 * n && seen < n; c++) begin
      cyc();
      if (bus.gnt != '0 && prev_gnt == '0) begin
        if (last_start >= 0)
          check({tag, "_spacing"}, 64'(c - last_start),
                64'(last_we ? 2 + WR_CYCLES : 2 + RD_LATENCY));
        last_start = c;
        last_we    = |(bus.gnt & bus.req_we);
      end
      prev_gnt = bus.gnt;
      if (bus.done != '0) begin
        seen++;
        if (drop_each) bus.req = bus.req & ~bus.done;
      end
    end
    check({tag, "_done_count"}, 64'(seen), 64'(n));
    bus.req = '0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset holds every output at zero, and stays quiet after release.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t1_reset_outs", all_outs(), 64'd0);
    end
    rst = 1'b0;
    cyc();
    check("t1_post_rst_outs", all_outs(), 64'd0);

    // Single write from requester 0.
    set_req(0, 1'b1, 16'h00A5, 16'hBEEF);
    expect_txn(0, 1'b1, 16'h00A5, 16'hBEEF);
    cyc();
    check("t2_gnt", 64'(bus.gnt), 64'd1);
    check("t2_wr_s", 64'(bus.xa_wr_s), 64'd1);
    check("t2_addr", 64'(bus.xa_addr), 64'h00A5);
    check("t2_wdata", 64'(bus.xa_data_wr), 64'hBEEF);
    check("t2_no_done_yet", 64'(bus.done), 64'd0);
    cyc();
    check("t2_done", 64'(bus.done), 64'd1);
    check("t2_gnt_held", 64'(bus.gnt), 64'd1);
    check("t2_wr_s_drop", 64'(bus.xa_wr_s), 64'd0);
    cyc();
    check("t2_idle_gnt_done", 64'({bus.gnt, bus.done}), 64'd0);
    bus.req = '0;
    cyc();
    check("t2_stay_idle", 64'(bus.gnt), 64'd0);

    // Single read from requester 1.
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    expect_txn(1, 1'b0, 16'h0010, 16'h0000);
    cyc();
    check("t3_rd_s", 64'(bus.xa_rd_s), 64'd1);
    check("t3_gnt", 64'(bus.gnt), 64'd2);
    check("t3_addr", 64'(bus.xa_addr), 64'h0010);
    check("t3_no_wr_s", 64'(bus.xa_wr_s), 64'd0);
    cyc();
    check("t3_rd_s_held", 64'(bus.xa_rd_s), 64'd1);
    check("t3_no_done_yet", 64'(bus.done), 64'd0);
    cyc();
    check("t3_done", 64'(bus.done), 64'd2);
    check("t3_rdata", 64'(bus.rdata), 64'h1234);
    check("t3_rd_s_drop", 64'(bus.xa_rd_s), 64'd0);
    cyc();
    bus.req = '0;
    check("t3_done_cleared", 64'(bus.done), 64'd0);
    check("t3_rdata_held", 64'(bus.rdata), 64'h1234);

    // Both requesters held: grants alternate 0,1,0,1.
    set_req(0, 1'b1, 16'h0100, 16'h1111);
    set_req(1, 1'b0, 16'h0200, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      expect_txn(0, 1'b1, 16'h0100, 16'h1111);
      expect_txn(1, 1'b0, 16'h0200, 16'h0000);
    end
    run(4, 1'b0, "t4");

    // Reset mid-read aborts the transaction without a done pulse.
    cyc();
    set_req(1, 1'b0, 16'h0030, 16'h0000);
    expect_txn(1, 1'b0, 16'h0030, 16'h0000);
    cyc();
    check("t5_rd_s", 64'(bus.xa_rd_s), 64'd1);
    check("t5_gnt", 64'(bus.gnt), 64'd2);
    check("t5_rdata_before", 64'(bus.rdata), 64'(slave_val(16'h0200)));
    rst = 1'b1;
    cyc();
    sb.delete();
    check("t5_outs_after_rst", all_outs(), 64'd0);
    set_req(0, 1'b1, 16'h0040, 16'hCAFE);
    expect_txn(0, 1'b1, 16'h0040, 16'hCAFE);
    expect_txn(1, 1'b0, 16'h0030, 16'h0000);
    cyc();
    check("t5_outs_in_rst", all_outs(), 64'd0);
    rst = 1'b0;
    run(2, 1'b1, "t5");

    // Requester 0 drops req right after its grant; the write still completes.
    cyc();
    set_req(0, 1'b1, 16'h0077, 16'h7777);
    expect_txn(0, 1'b1, 16'h0077, 16'h7777);
    cyc();
    check("t6_gnt", 64'(bus.gnt), 64'd1);
    check("t6_wr_s", 64'(bus.xa_wr_s), 64'd1);
    bus.req = '0;
    cyc();
    check("t6_done", 64'(bus.done), 64'd1);
    check("t6_wr_s_drop", 64'(bus.xa_wr_s), 64'd0);
    cyc();
    check("t6_idle", 64'({bus.gnt, bus.done}), 64'd0);
    cyc();
    check("t6_stay_idle", 64'({bus.gnt, bus.xa_wr_s, bus.xa_rd_s}), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
